// File: rtl/xtea_pkg.sv
// Shared constants, state encoding and helpers for the XTEA key-schedule engine.
package xtea_pkg;

  localparam int          DEFAULT_WORD_W  = 32;
  localparam int          DEFAULT_SHIFT_Z = 11;
  localparam logic [31:0] XTEA_DELTA      = 32'h9E3779B9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN_A = 2'd1,
    RUN_B = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Decryption starts from delta*rounds; callers truncate to their word width.
  function automatic logic [63:0] decrypt_init_sum(input logic [63:0] delta,
                                                   input int unsigned rounds);
    return delta * 64'(rounds);
  endfunction

endpackage

// File: rtl/key_word_mux.sv
// Selects one of four key words from the running sum: low bits for the y-half,
// bits above SHIFT_Z for the z-half.
module key_word_mux #(
  parameter int WORD_W  = 32,
  parameter int SHIFT_Z = 11
) (
  input  logic [4*WORD_W-1:0] key,
  input  logic [WORD_W-1:0]   sum,
  input  logic                is_z,
  output logic [WORD_W-1:0]   word
);

  logic [WORD_W-1:0] idx_full;

  always_comb begin
    idx_full = (is_z ? (sum >> SHIFT_Z) : sum) & WORD_W'(3);
    word     = '0;
    case (idx_full)
      WORD_W'(0): word = key[0*WORD_W +: WORD_W];
      WORD_W'(1): word = key[1*WORD_W +: WORD_W];
      WORD_W'(2): word = key[2*WORD_W +: WORD_W];
      WORD_W'(3): word = key[3*WORD_W +: WORD_W];
      default:    word = '0;
    endcase
  end

endmodule

// File: rtl/xtea_key_schedule.sv
// Self-sequencing XTEA key schedule: walks the running sum through ROUNDS full
// rounds and hands each half-round's key word to the datapath via valid/ready.
module xtea_key_schedule
  import xtea_pkg::*;
#(
  parameter int                WORD_W  = DEFAULT_WORD_W,
  parameter int                ROUNDS  = 32,
  parameter logic [WORD_W-1:0] DELTA   = WORD_W'(XTEA_DELTA),
  parameter int                SHIFT_Z = DEFAULT_SHIFT_Z
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         key_load,
  input  logic [4*WORD_W-1:0]          key_in,
  input  logic                         start,
  input  logic                         decrypt,
  input  logic                         abort,
  output logic                         seg_valid,
  input  logic                         seg_ready,
  output logic [WORD_W-1:0]            key_segment,
  output logic [WORD_W-1:0]            sum_out,
  output logic                         seg_is_z,
  output logic [$clog2(ROUNDS+1)-1:0]  round_idx,
  output logic                         busy,
  output logic                         done
);

  localparam int                RIDX_W   = $clog2(ROUNDS + 1);
  localparam logic [WORD_W-1:0] SUM_INIT = WORD_W'(decrypt_init_sum(64'(DELTA), ROUNDS));
  localparam logic [RIDX_W-1:0] LAST_RND = RIDX_W'(ROUNDS - 1);

  state_t              state, state_n;
  logic [4*WORD_W-1:0] key_q;
  logic [WORD_W-1:0]   sum_q;
  logic [RIDX_W-1:0]   round_q;
  logic                dec_mode;
  logic                fire;
  logic                accept_cmd;

  assign busy       = (state == RUN_A) || (state == RUN_B);
  assign seg_valid  = busy;
  assign done       = (state == DONE);
  assign fire       = seg_valid && seg_ready;
  assign accept_cmd = !busy;
  assign sum_out    = sum_q;
  assign round_idx  = round_q;
  // Encrypt presents y then z; decrypt reverses the order within a round.
  assign seg_is_z   = busy && ((state == RUN_B) ^ dec_mode);

  key_word_mux #(
    .WORD_W (WORD_W),
    .SHIFT_Z(SHIFT_Z)
  ) u_key_word_mux (
    .key (key_q),
    .sum (sum_q),
    .is_z(seg_is_z),
    .word(key_segment)
  );

  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (start) state_n = RUN_A;
      RUN_A: begin
        if (abort)     state_n = IDLE;
        else if (fire) state_n = RUN_B;
      end
      RUN_B: begin
        if (abort)     state_n = IDLE;
        else if (fire) state_n = (round_q == LAST_RND) ? DONE : RUN_A;
      end
      DONE:  state_n = start ? RUN_A : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      key_q    <= '0;
      sum_q    <= '0;
      round_q  <= '0;
      dec_mode <= 1'b0;
    end else begin
      state <= state_n;
      if (accept_cmd && key_load) key_q <= key_in;
      if (accept_cmd && start) begin
        round_q  <= '0;
        sum_q    <= decrypt ? SUM_INIT : '0;
        dec_mode <= decrypt;
      end else if (fire && !abort) begin
        // sum moves between the two halves; the round counts on the second.
        if (state == RUN_A) sum_q   <= dec_mode ? (sum_q - DELTA) : (sum_q + DELTA);
        else                round_q <= round_q + RIDX_W'(1);
      end
    end
  end

endmodule

// File: doc/xtea_key_schedule.md
# xtea_key_schedule

Sequential key-schedule engine for the XTEA datapath. It holds a loaded 128-bit key and steps the running `sum` through a programmable number of rounds in encrypt or decrypt order. For each half-round it presents the selected 32-bit key word and the matching `sum` to the round datapath through a valid/ready handshake. It replaces per-round combinational key selection with a self-sequencing, stallable unit.

## Interface
- `WORD_W`, 32: key word and `sum` width; key is 4×`WORD_W`.
- `ROUNDS`, 32: number of full rounds per run; must be ≥1.
- `DELTA`, 32'h9E3779B9: schedule constant, truncated to `WORD_W`.
- `SHIFT_Z`, 11: right-shift applied to `sum` for z-half index selection.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `key_load` in 1: capture `key_in` (honoured only in IDLE/DONE).
- `key_in` in 4*WORD_W: word *i* = bits [(i+1)*WORD_W-1 : i*WORD_W].
- `start` in 1: begin run (honoured only in IDLE/DONE).
- `decrypt` in 1: mode, sampled with `start`.
- `abort` in 1: terminate run.
- `seg_valid` out 1: key segment presented.
- `seg_ready` in 1: datapath consumes the segment.
- `key_segment` out WORD_W: selected key word.
- `sum_out` out WORD_W: `sum` used with `key_segment`.
- `seg_is_z` out 1: 0 = y-half (index `sum`&3), 1 = z-half (index (`sum`>>`SHIFT_Z`)&3).
- `round_idx` out $clog2(ROUNDS+1): completed full rounds.
- `busy` out 1: state is RUN_A or RUN_B.
- `done` out 1: one-cycle pulse after the last half is consumed.

## Operation
- States: IDLE, RUN_A, RUN_B, DONE. A handshake fires when `seg_valid`&`seg_ready`.
- IDLE/DONE + `start`: `round_idx`←0; `sum`←0 (encrypt) or `DELTA`*`ROUNDS` mod 2^`WORD_W` (decrypt); mode latched; →RUN_A.
- Encrypt:
  - RUN_A presents y-half with the current `sum`. On fire: `sum`+=`DELTA`, →RUN_B.
  - RUN_B presents z-half with the updated `sum`. On fire: `round_idx`++; →DONE if `round_idx`==`ROUNDS`-1, else →RUN_A.
- Decrypt:
  - RUN_A presents z-half with the current `sum`. On fire: `sum`-=`DELTA`, →RUN_B.
  - RUN_B presents y-half. On fire: same round/exit rule as encrypt.
- DONE: `done`=1 for one cycle; →IDLE, or →RUN_A if `start` is asserted.
- `sum` arithmetic wraps modulo 2^`WORD_W`. Index is always 2 bits.
- `key_load` in IDLE/DONE writes the key register. While busy it is ignored and the key stays frozen.
- `key_load`+`start` in the same cycle: the run uses the new key.
- `abort` while busy: →IDLE next cycle, no `done`, and no state update from a simultaneous fire. `abort` outside a run is ignored.
- `rst` has priority over everything, including mid-run: state IDLE, key register 0, `sum` 0, `round_idx` 0.

## Timing
- Reset values: `seg_valid` 0, `key_segment` 0, `sum_out` 0, `seg_is_z` 0, `round_idx` 0, `busy` 0, `done` 0.
- `start` at cycle t: `seg_valid`=1 at t+1.
- Each half holds until fired. `key_segment`/`sum_out`/`seg_is_z` are stable while `seg_valid` && !`seg_ready`.
- Minimum run: 2*`ROUNDS` cycles of `seg_valid`, then `done` on the next cycle.
- Back-to-back runs: `start` during DONE gives `seg_valid` on the following cycle.
- All outputs are functions of registers only; there is no combinational input→output path.

## Structure
- Shared package `xtea_pkg`: `DELTA`, default `WORD_W`, `SHIFT_Z`, the state enum, and a function computing the decrypt initial `sum`.
- One sub-module, `key_word_mux`: a parametrised 4-way word selector taking key, `sum`, and the half flag, returning the key word.

## Test plan
- Key {k3..k0} = {33333333,22222222,11111111,00000000}, encrypt, `seg_ready`=1 -> first three segments: (`sum` 0, key 00000000, y), (9E3779B9, 33333333, z), (9E3779B9, 11111111, y). `done` follows 64 segments; final `sum` C6EF3720.
- Same key, decrypt -> first segments: (C6EF3720, 22222222, z), (28B7BD67, 33333333, y). `done` follows 64 segments; final `sum` 0.
- `seg_ready` low 5 cycles mid-run -> outputs unchanged. Total run length grows by exactly 5 cycles.
- `key_load` with a new key at round 10 -> ignored. `key_load`+`start` together in IDLE -> first segment uses the new key.
- `abort` at round 7 with a simultaneous fire -> IDLE next cycle, `done` never asserted. `rst` mid-run -> all outputs and key register return to 0.
- `ROUNDS`=1 -> exactly two segments, `done` on the following cycle. `start` during DONE -> new run begins without passing through IDLE.
